// File: rtl/tx_arq_ctrl.sv
// tx_arq_ctrl: transmit-side ARQ controller.
// - Runs the SEQN/ARQN handshake over a 2-slot payload ring.
// - Decides the packet type at every own TX slot.
// - Handles host flushes, automatic flush after MAX_RETX retransmits, and
//   peer FLOW stop.
module tx_arq_ctrl #(
    parameter int MAX_RETX = 15
) (
    input  logic       clk_6M,
    input  logic       rstz,
    input  logic       conn_new_p,
    input  logic       tx_slot_p,
    input  logic       rx_hdr_valid_p,
    input  logic       rx_ARQN,
    input  logic       rx_FLOW,
    input  logic       host_load_p,
    input  logic       flush_p,
    output logic       tx_SEQN,
    output logic [1:0] tx_type,
    output logic       tx_slot_sel,
    output logic       buf_free,
    output logic       tx_done_p,
    output logic       flush_done_p,
    output logic       load_ovf_p
);

    localparam logic [3:0] MAX_R = 4'(MAX_RETX);

    typedef enum logic [1:0] {S_EMPTY, S_PEND, S_WAIT} st_t;

    st_t        st, st_nxt;
    logic       head, head_nxt, tail, tail_nxt;
    logic [1:0] occ, occ_nxt;
    logic [3:0] retx_cnt, retx_nxt;
    logic       flow_ok, flow_nxt, flush_pend, fpend_nxt;
    logic       seqn_nxt, sel_nxt, done_nxt, fdone_nxt, ovf_nxt;
    logic [1:0] type_nxt;

    assign buf_free = (occ != 2'd2);

    // State and registered outputs; outputs only move when the decision logic says so.
    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            st           <= S_EMPTY;
            head         <= 1'b0;
            tail         <= 1'b0;
            occ          <= 2'd0;
            retx_cnt     <= 4'd0;
            flow_ok      <= 1'b1;
            flush_pend   <= 1'b0;
            tx_SEQN      <= 1'b1;
            tx_type      <= 2'd0;
            tx_slot_sel  <= 1'b0;
            tx_done_p    <= 1'b0;
            flush_done_p <= 1'b0;
            load_ovf_p   <= 1'b0;
        end else begin
            st           <= st_nxt;
            head         <= head_nxt;
            tail         <= tail_nxt;
            occ          <= occ_nxt;
            retx_cnt     <= retx_nxt;
            flow_ok      <= flow_nxt;
            flush_pend   <= fpend_nxt;
            tx_SEQN      <= seqn_nxt;
            tx_type      <= type_nxt;
            tx_slot_sel  <= sel_nxt;
            tx_done_p    <= done_nxt;
            flush_done_p <= fdone_nxt;
            load_ovf_p   <= ovf_nxt;
        end
    end

    // Same-cycle events applied in order: rx header, flush, slot decision, host load.
    always_comb begin
        st_nxt    = st;
        head_nxt  = head;
        tail_nxt  = tail;
        occ_nxt   = occ;
        retx_nxt  = retx_cnt;
        flow_nxt  = flow_ok;
        fpend_nxt = flush_pend | flush_p;
        seqn_nxt  = tx_SEQN;
        type_nxt  = tx_type;
        sel_nxt   = tx_slot_sel;
        done_nxt  = 1'b0;
        fdone_nxt = 1'b0;
        ovf_nxt   = 1'b0;

        if (conn_new_p) begin
            st_nxt    = S_EMPTY;
            head_nxt  = 1'b0;
            tail_nxt  = 1'b0;
            occ_nxt   = 2'd0;
            retx_nxt  = 4'd0;
            flow_nxt  = 1'b1;
            fpend_nxt = 1'b0;
            seqn_nxt  = 1'b1;
        end else begin
            // Peer response: FLOW always latched, ACK releases an outstanding head.
            if (rx_hdr_valid_p) begin
                flow_nxt = rx_FLOW;
                if (st == S_WAIT && rx_ARQN) begin
                    head_nxt = ~head;
                    occ_nxt  = occ - 2'd1;
                    retx_nxt = 4'd0;
                    done_nxt = 1'b1;
                    st_nxt   = (occ_nxt != 2'd0) ? S_PEND : S_EMPTY;
                end
            end
            if (tx_slot_p) begin
                // Host flush or retransmit limit discards the head before deciding.
                if (fpend_nxt || (st_nxt == S_WAIT && retx_nxt >= MAX_R)) begin
                    fdone_nxt = 1'b1;
                    fpend_nxt = 1'b0;
                    if (st_nxt != S_EMPTY) begin
                        head_nxt = ~head_nxt;
                        occ_nxt  = occ_nxt - 2'd1;
                        retx_nxt = 4'd0;
                        st_nxt   = (occ_nxt != 2'd0) ? S_PEND : S_EMPTY;
                    end
                end
                if (!flow_nxt || st_nxt == S_EMPTY) begin
                    type_nxt = 2'd0;
                end else if (st_nxt == S_PEND) begin
                    seqn_nxt = ~tx_SEQN;
                    type_nxt = 2'd1;
                    sel_nxt  = head_nxt;
                    st_nxt   = S_WAIT;
                end else begin
                    type_nxt = 2'd2;
                    sel_nxt  = head_nxt;
                    if (retx_nxt != 4'hF) retx_nxt = retx_nxt + 4'd1;
                end
            end
            // Host load sees post-release occupancy, so load+ACK keeps occ steady.
            if (host_load_p) begin
                if (occ_nxt != 2'd2) begin
                    tail_nxt = ~tail_nxt;
                    occ_nxt  = occ_nxt + 2'd1;
                    if (st_nxt == S_EMPTY) st_nxt = S_PEND;
                end else begin
                    ovf_nxt = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tx_arq_ctrl.sv
// Bench for tx_arq_ctrl: directed vector table, hand sequences, random run.
// Two instances (default limit and limit 2) share the stimulus.
module tb_tx_arq_ctrl;

    logic clk_6M = 1'b0;
    logic rstz = 1'b0;
    logic conn_new_p = 0, tx_slot_p = 0, rx_hdr_valid_p = 0, rx_ARQN = 0, rx_FLOW = 1;
    logic host_load_p = 0, flush_p = 0;

    logic       a_seqn, a_sel, a_bfree, a_done, a_fdone, a_ovf;
    logic [1:0] a_type;
    logic       b_seqn, b_sel, b_bfree, b_done, b_fdone, b_ovf;
    logic [1:0] b_type;

    always #5 clk_6M = ~clk_6M;

    tx_arq_ctrl dut (
        .clk_6M(clk_6M), .rstz(rstz), .conn_new_p(conn_new_p), .tx_slot_p(tx_slot_p),
        .rx_hdr_valid_p(rx_hdr_valid_p), .rx_ARQN(rx_ARQN), .rx_FLOW(rx_FLOW),
        .host_load_p(host_load_p), .flush_p(flush_p),
        .tx_SEQN(a_seqn), .tx_type(a_type), .tx_slot_sel(a_sel), .buf_free(a_bfree),
        .tx_done_p(a_done), .flush_done_p(a_fdone), .load_ovf_p(a_ovf));

    tx_arq_ctrl #(.MAX_RETX(2)) dut2 (
        .clk_6M(clk_6M), .rstz(rstz), .conn_new_p(conn_new_p), .tx_slot_p(tx_slot_p),
        .rx_hdr_valid_p(rx_hdr_valid_p), .rx_ARQN(rx_ARQN), .rx_FLOW(rx_FLOW),
        .host_load_p(host_load_p), .flush_p(flush_p),
        .tx_SEQN(b_seqn), .tx_type(b_type), .tx_slot_sel(b_sel), .buf_free(b_bfree),
        .tx_done_p(b_done), .flush_done_p(b_fdone), .load_ovf_p(b_ovf));

    typedef struct packed {
        bit conn, slot, rxv, rxa, rxf, load, flush;
    } in_t;

    typedef struct packed {
        bit conn, slot, rxv, rxa, rxf, load, flush;
        int typ, seqn, sel, done, fdone, ovf, bfree;
    } tv_t;

    // Model state: n payloads queued, the first in slot hd; sent = head on air.
    typedef struct packed {
        int n, hd, retx, ttype;
        bit sent, seqn, sel, flow, fpend, done, fdone, ovf;
    } ms_t;

    int total = 0, bad = 0;
    ms_t m1, m2;

    function automatic ms_t minit();
        ms_t m;
        m = '0;
        m.seqn = 1'b1;
        m.flow = 1'b1;
        return m;
    endfunction

    function automatic ms_t mstep(ms_t s, in_t v, int maxr);
        ms_t m = s;
        m.done = 0; m.fdone = 0; m.ovf = 0;
        if (v.conn) begin
            m.n = 0; m.hd = 0; m.sent = 0; m.seqn = 1; m.flow = 1; m.fpend = 0; m.retx = 0;
            return m;
        end
        if (v.rxv) begin
            m.flow = v.rxf;
            if (m.sent && v.rxa) begin
                m.hd = (m.hd + 1) % 2; m.n = m.n - 1; m.sent = 0; m.retx = 0; m.done = 1;
            end
        end
        if (v.flush) m.fpend = 1;
        if (v.slot) begin
            if (m.fpend || (m.sent && m.retx >= maxr)) begin
                m.fdone = 1; m.fpend = 0;
                if (m.n > 0) begin
                    m.hd = (m.hd + 1) % 2; m.n = m.n - 1; m.sent = 0; m.retx = 0;
                end
            end
            if (!m.flow || m.n == 0) m.ttype = 0;
            else if (!m.sent) begin
                m.seqn = !m.seqn; m.ttype = 1; m.sel = m.hd[0]; m.sent = 1;
            end else begin
                m.ttype = 2; m.sel = m.hd[0]; m.retx = (m.retx < 15) ? m.retx + 1 : 15;
            end
        end
        if (v.load) begin
            if (m.n < 2) m.n = m.n + 1;
            else m.ovf = 1;
        end
        return m;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("a.type", a_type, m1.ttype);   chk("a.seqn", a_seqn, m1.seqn);
        chk("a.sel", a_sel, m1.sel);       chk("a.done", a_done, m1.done);
        chk("a.fdone", a_fdone, m1.fdone); chk("a.ovf", a_ovf, m1.ovf);
        chk("a.bfree", a_bfree, int'(m1.n < 2));
        chk("b.type", b_type, m2.ttype);   chk("b.seqn", b_seqn, m2.seqn);
        chk("b.sel", b_sel, m2.sel);       chk("b.done", b_done, m2.done);
        chk("b.fdone", b_fdone, m2.fdone); chk("b.ovf", b_ovf, m2.ovf);
        chk("b.bfree", b_bfree, int'(m2.n < 2));
    endtask

    // One clock: drive inputs, step both models at the edge, compare 1 time unit later.
    task automatic cyc(input in_t v);
        conn_new_p = v.conn; tx_slot_p = v.slot; rx_hdr_valid_p = v.rxv;
        rx_ARQN = v.rxa; rx_FLOW = v.rxf; host_load_p = v.load; flush_p = v.flush;
        @(posedge clk_6M);
        m1 = mstep(m1, v, 15);
        m2 = mstep(m2, v, 2);
        #1;
        cmp_all();
        conn_new_p = 0; tx_slot_p = 0; rx_hdr_valid_p = 0; host_load_p = 0; flush_p = 0;
    endtask

    function automatic in_t mk(bit conn, bit slot, bit rxv, bit rxa, bit rxf, bit load, bit flush);
        in_t v;
        v.conn = conn; v.slot = slot; v.rxv = rxv; v.rxa = rxa; v.rxf = rxf;
        v.load = load; v.flush = flush;
        return v;
    endfunction

    tv_t tv[28];

    initial begin
        in_t v;
        // conn slot rxv rxa rxf load flush | type seqn sel done fdone ovf bfree
        tv[0]  = '{0,0,0,0,1,1,0, 0,1,0,0,0,0,1};
        tv[1]  = '{0,1,0,0,1,0,0, 1,0,0,0,0,0,1};
        tv[2]  = '{0,0,1,1,1,0,0, 1,0,0,1,0,0,1};
        tv[3]  = '{0,1,0,0,1,0,0, 0,0,0,0,0,0,1};
        tv[4]  = '{0,0,0,0,1,1,0, 0,0,0,0,0,0,1};
        tv[5]  = '{0,1,0,0,1,0,0, 1,1,1,0,0,0,1};
        tv[6]  = '{0,0,1,0,1,0,0, 1,1,1,0,0,0,1};
        tv[7]  = '{0,1,0,0,1,0,0, 2,1,1,0,0,0,1};
        tv[8]  = '{0,1,0,0,1,0,0, 2,1,1,0,0,0,1};
        tv[9]  = '{0,1,0,0,1,0,0, 2,1,1,0,0,0,1};
        tv[10] = '{0,0,1,1,1,0,0, 2,1,1,1,0,0,1};
        tv[11] = '{0,1,0,0,1,0,0, 0,1,1,0,0,0,1};
        tv[12] = '{0,0,0,0,1,1,0, 0,1,1,0,0,0,1};
        tv[13] = '{0,0,0,0,1,1,0, 0,1,1,0,0,0,0};
        tv[14] = '{0,0,0,0,1,1,0, 0,1,1,0,0,1,0};
        tv[15] = '{0,1,0,0,1,0,0, 1,0,0,0,0,0,0};
        tv[16] = '{0,0,1,1,1,1,0, 1,0,0,1,0,0,0};
        tv[17] = '{0,0,1,0,0,0,0, 1,0,0,0,0,0,0};
        tv[18] = '{0,1,0,0,1,0,0, 0,0,0,0,0,0,0};
        tv[19] = '{0,0,1,0,1,0,0, 0,0,0,0,0,0,0};
        tv[20] = '{0,1,0,0,1,0,0, 1,1,1,0,0,0,0};
        tv[21] = '{1,0,0,0,1,0,0, 1,1,1,0,0,0,1};
        tv[22] = '{0,1,0,0,1,0,0, 0,1,1,0,0,0,1};
        tv[23] = '{0,0,0,0,1,1,0, 0,1,1,0,0,0,1};
        tv[24] = '{0,0,0,0,1,0,1, 0,1,1,0,0,0,1};
        tv[25] = '{0,1,0,0,1,0,0, 0,1,1,0,1,0,1};
        tv[26] = '{0,0,0,0,1,0,1, 0,1,1,0,0,0,1};
        tv[27] = '{0,1,0,0,1,0,0, 0,1,1,0,1,0,1};

        m1 = minit();
        m2 = minit();
        repeat (2) @(posedge clk_6M);
        #1;
        chk("rst.type", a_type, 0);   chk("rst.seqn", a_seqn, 1);
        chk("rst.sel", a_sel, 0);     chk("rst.bfree", a_bfree, 1);
        chk("rst.done", a_done, 0);   chk("rst.fdone", a_fdone, 0);
        chk("rst.ovf", a_ovf, 0);
        rstz = 1'b1;

        // Directed vector table against the default-limit instance.
        for (int i = 0; i < 28; i++) begin
            v = mk(tv[i].conn, tv[i].slot, tv[i].rxv, tv[i].rxa, tv[i].rxf,
                   tv[i].load, tv[i].flush);
            cyc(v);
            chk($sformatf("tv%0d.type", i), a_type, tv[i].typ);
            chk($sformatf("tv%0d.seqn", i), a_seqn, tv[i].seqn);
            chk($sformatf("tv%0d.sel", i), a_sel, tv[i].sel);
            chk($sformatf("tv%0d.done", i), a_done, tv[i].done);
            chk($sformatf("tv%0d.fdone", i), a_fdone, tv[i].fdone);
            chk($sformatf("tv%0d.ovf", i), a_ovf, tv[i].ovf);
            chk($sformatf("tv%0d.bfree", i), a_bfree, tv[i].bfree);
        end

        // Limit-2 instance: two unanswered retransmits, then auto-flush.
        cyc(mk(1,0,0,0,1,0,0));
        cyc(mk(0,0,0,0,1,1,0));
        cyc(mk(0,1,0,0,1,0,0));
        chk("lim.send", b_type, 1);
        chk("lim.seqn", b_seqn, 0);
        cyc(mk(0,1,0,0,1,0,0));
        chk("lim.retx1", b_type, 2);
        cyc(mk(0,1,0,0,1,0,0));
        chk("lim.retx2", b_type, 2);
        cyc(mk(0,1,0,0,1,0,0));
        chk("lim.flush_type", b_type, 0);
        chk("lim.flush_done", b_fdone, 1);
        chk("lim.bfree", b_bfree, 1);
        chk("lim.nolim_type", a_type, 2);

        // Reset mid-WAIT: payload dropped, a later ACK releases nothing.
        cyc(mk(1,0,0,0,1,0,0));
        cyc(mk(0,0,0,0,1,1,0));
        cyc(mk(0,1,0,0,1,0,0));
        rstz = 1'b0;
        #1;
        m1 = minit();
        m2 = minit();
        cmp_all();
        @(posedge clk_6M);
        #1;
        rstz = 1'b1;
        cyc(mk(0,0,1,1,1,0,0));
        chk("rstwait.done", a_done, 0);
        chk("rstwait.seqn", a_seqn, 1);
        cyc(mk(0,1,0,0,1,0,0));
        chk("rstwait.type", a_type, 0);

        // Random run against both models.
        for (int i = 0; i < 3000; i++) begin
            v.conn  = ($urandom_range(0, 63) == 0);
            v.slot  = ($urandom_range(0, 3) == 0);
            v.rxv   = ($urandom_range(0, 3) == 0);
            v.rxa   = $urandom_range(0, 1);
            v.rxf   = ($urandom_range(0, 7) != 0);
            v.load  = ($urandom_range(0, 2) == 0);
            v.flush = ($urandom_range(0, 23) == 0);
            cyc(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_arq_ctrl.md
TX_ARQ_CTRL -- requirements
Module: tx_arq_ctrl

Interface
REQ-001 SHALL have parameter MAX_RETX, default 15, meaning the retransmission count at which the head payload is auto-flushed (range 1..15).
REQ-002 SHALL have port clk_6M  input  1  6 MHz clock.
REQ-003 SHALL have port rstz  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port conn_new_p  input  1  new master/slave connection pulse.
REQ-005 SHALL have port tx_slot_p  input  1  own TX slot start; packet decision point.
REQ-006 SHALL have port rx_hdr_valid_p  input  1  received header HEC-good and LT_ADDR-matched.
REQ-007 SHALL have port rx_ARQN  input  1  peer ARQN bit, valid with rx_hdr_valid_p.
REQ-008 SHALL have port rx_FLOW  input  1  peer FLOW bit, valid with rx_hdr_valid_p.
REQ-009 SHALL have port host_load_p  input  1  host has written one payload into the tail slot.
REQ-010 SHALL have port flush_p  input  1  host flush command.
REQ-011 SHALL have port tx_SEQN  output  1  SEQN for the packet being sent.
REQ-012 SHALL have port tx_type  output  2  0=NULL/POLL, 1=new data, 2=retransmit, 3 reserved (never driven).
REQ-013 SHALL have port tx_slot_sel  output  1  buffer slot index of payload sent.
REQ-014 SHALL have port buf_free  output  1  high when occupancy < 2.
REQ-015 SHALL have ports tx_done_p, flush_done_p, load_ovf_p  output  1 each  single-cycle event pulses.

Function
REQ-016 SHALL hold a 2-slot payload ring: head pointer, tail pointer (1 bit each, wrapping), occupancy 0..2.
REQ-017 SHALL run head state machine: EMPTY (occ=0), PEND (head loaded, unsent), WAIT (head sent, response outstanding).
REQ-018 host_load_p with occ<2 SHALL advance tail, occ+1; with occ=2 SHALL be dropped and pulse load_ovf_p next cycle.
REQ-019 rx_hdr_valid_p SHALL latch rx_FLOW into flow_ok (reset 1).
REQ-020 In WAIT, rx_hdr_valid_p with rx_ARQN=1 SHALL release head (head+1, occ-1), pulse tx_done_p, clear retx_cnt, go PEND if occ remains >0 else EMPTY.
REQ-021 In WAIT, rx_hdr_valid_p with rx_ARQN=0, or no rx_hdr_valid_p before next tx_slot_p, SHALL be NAK: stay WAIT.
REQ-022 At tx_slot_p, registered outputs SHALL update one cycle later and hold until next tx_slot_p.
REQ-023 At tx_slot_p with flow_ok=0 or state EMPTY: tx_type=0, tx_SEQN unchanged.
REQ-024 At tx_slot_p in PEND: toggle tx_SEQN, tx_type=1, tx_slot_sel=head, go WAIT.
REQ-025 At tx_slot_p in WAIT: tx_type=2, same tx_SEQN, retx_cnt+1 (4-bit, saturating).
REQ-026 flush_p SHALL set flush_pend; at next tx_slot_p with state WAIT or PEND, head SHALL be discarded (head+1, occ-1), flush_done_p pulsed, flush_pend cleared, retx_cnt cleared, slot decided per REQ-023/024 against the new head in the same decision; flush_pend with EMPTY SHALL clear with flush_done_p.
REQ-027 retx_cnt reaching MAX_RETX in WAIT SHALL act as flush_p at the next tx_slot_p.
REQ-028 Same-cycle ordering SHALL be: rx_hdr_valid_p processing, then flush, then tx_slot_p decision, then host_load_p; a load concurrent with release SHALL leave occ unchanged.
REQ-029 conn_new_p SHALL empty the ring, set tx_SEQN=1, flow_ok=1, state EMPTY, clear flush_pend and retx_cnt; it overrides all same-cycle events.

Reset
REQ-030 On rstz low: tx_SEQN=1, tx_type=0, tx_slot_sel=0, occ=0, pointers=0, retx_cnt=0, flow_ok=1, flush_pend=0, state EMPTY, buf_free=1, all pulses 0.
REQ-031 Reset mid-WAIT SHALL discard outstanding payload with no tx_done_p.

Verification
REQ-032 Load one payload, tx_slot_p, ACK (ARQN=1), tx_slot_p -> tx_type 1 SEQN 0, tx_done_p once, then tx_type 0 SEQN 0.
REQ-033 Load, send, three NAKs -> tx_type 2 three times with SEQN 0, retx_cnt=3; then ACK -> release.
REQ-034 MAX_RETX=2, no response -> after 2 retransmits next tx_slot_p flushes, flush_done_p, tx_type 0.
REQ-035 Three loads back-to-back -> third pulses load_ovf_p, buf_free=0, occ=2; ACK + load same cycle -> occ=2.
REQ-036 rx_FLOW=0 latched with occ=1 PEND -> tx_type 0, SEQN unchanged; FLOW=1 -> new packet sent.
REQ-037 conn_new_p during WAIT -> occ=0, SEQN=1, EMPTY, no tx_done_p.
